// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline.
// Latency: ReadDataM is combinational from the M inputs; the W outputs follow one cycle later.
// Backpressure: none; the stage advances every cycle, and decode inserts bubbles upstream.
//
// Ports:
//   Clock, Reset        single clock; synchronous active-high reset
//   ALUResultM          byte address for lw/sw, otherwise the ALU result
//   WriteDataM          store data
//   WriteRegM           destination register
//   RegWriteM, MemReadM, MemWriteM, MemtoRegM   M-stage control
//   ReadDataM           M-stage forwarding value to decode
//   ResultW, WriteRegW, RegWriteW               register-file writeback port
//   RetireCountW        count of retired register writes
//   MisalignW           sticky misaligned-access flag
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to squash misaligned loads and stores
// and to raise MisalignW. Without it, the low address bits are ignored.
module mem_wb_stage #(
  parameter int DMEM_WORDS = 512
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  output logic [31:0] ReadDataM,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic [31:0] RetireCountW,
  output logic        MisalignW
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] index;
  logic [31:0]   load;
  logic          misalign;

  // The upper address bits are dropped, so the address wraps modulo the memory size.
  assign index = ALUResultM[AW+1:2];

  // The read is asynchronous. A store in the same cycle commits at the edge,
  // so a load and a store in one instruction see the pre-write word.
  assign load      = mem[index];
  assign ReadDataM = MemtoRegM ? load : ALUResultM;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (MemReadM | MemWriteM) & (ALUResultM[1:0] != 2'b00);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      MisalignW <= 1'b0;
    end else if (misalign) begin
      MisalignW <= 1'b1;
    end
  end
`else
  // MemReadM only qualifies the alignment check, so it has no effect in this build.
  logic unused_memread;
  assign unused_memread = MemReadM;
  assign misalign       = 1'b0;
  assign MisalignW      = 1'b0;
`endif

  // The data memory is never cleared by Reset. A store during a reset cycle is dropped.
  always_ff @(posedge Clock) begin
    if (!Reset && MemWriteM && !misalign) begin
      mem[index] <= WriteDataM;
    end
  end

  // MEM/WB register. A write to $0 is squashed here so that downstream logic
  // and the retire counter never see it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ResultW      <= 32'd0;
      WriteRegW    <= 5'd0;
      RegWriteW    <= 1'b0;
      RetireCountW <= 32'd0;
    end else begin
      ResultW   <= ReadDataM;
      WriteRegW <= WriteRegM;
      RegWriteW <= RegWriteM & (WriteRegM != 5'd0) & ~misalign;
      // The counter increments when the instruction leaves W.
      if (RegWriteW) begin
        RetireCountW <= RetireCountW + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int WORDS = 512;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemReadM, MemWriteM, MemtoRegM;
  logic [31:0] ReadDataM, ResultW, RetireCountW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, MisalignW;

  mem_wb_stage #(.DMEM_WORDS(WORDS)) dut (
    .Clock(Clock), .Reset(Reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ReadDataM(ReadDataM), .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .RetireCountW(RetireCountW), .MisalignW(MisalignW)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int asserts = 0;
  int fails   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard entries, each tagged with the cycle in which it is due.
  typedef struct {
    int          due;
    logic [31:0] rd;
  } rd_e_t;
  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  wr;
    logic        rw;
    logic [31:0] cnt;
    logic        mis;
  } wb_e_t;

  rd_e_t rd_q[$];
  wb_e_t wb_q[$];

  // Reference model: word-addressed memory (unwritten words read as zero) plus W state.
  logic [31:0] mdl_mem [int];
  logic [31:0] m_res = 0, m_cnt = 0;
  logic [4:0]  m_wr = 0;
  logic        m_rw = 0, m_mis = 0;

  task automatic step(input logic rst, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] wr, input logic rw, input logic mr,
                      input logic mw, input logic m2r);
    int          key;
    logic [31:0] ld, rd;
    logic        bad;
    @(posedge Clock);
    #1;
    Reset = rst; ALUResultM = alu; WriteDataM = wd; WriteRegM = wr;
    RegWriteM = rw; MemReadM = mr; MemWriteM = mw; MemtoRegM = m2r;
    key = int'((alu / 4) % WORDS);
    ld  = mdl_mem.exists(key) ? mdl_mem[key] : 32'd0;
    rd  = m2r ? ld : alu;
    rd_q.push_back('{cyc, rd});
    if (rst) begin
      m_res = 0; m_wr = 0; m_rw = 0; m_cnt = 0; m_mis = 0;
    end else begin
      bad = ALIGN && (mr || mw) && (alu % 4 != 0);
      if (m_rw) m_cnt = m_cnt + 1;
      m_res = rd;
      m_wr  = wr;
      m_rw  = rw && (wr != 0) && !bad;
      if (bad) m_mis = 1'b1;
      if (mw && !bad) mdl_mem[key] = wd;
    end
    wb_q.push_back('{cyc + 1, m_res, m_wr, m_rw, m_cnt, m_mis});
  endtask

  // Monitor: compares the DUT against whichever expectations are due this cycle.
  rd_e_t re;
  wb_e_t we;
  always @(negedge Clock) begin
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      re = rd_q.pop_front();
      chk("ReadDataM", ReadDataM, re.rd);
    end
    if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
      we = wb_q.pop_front();
      chk("ResultW", ResultW, we.res);
      chk("WriteRegW", {27'd0, WriteRegW}, {27'd0, we.wr});
      chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, we.rw});
      chk("RetireCountW", RetireCountW, we.cnt);
      chk("MisalignW", {31'd0, MisalignW}, {31'd0, we.mis});
    end
  end

  int pool [6] = '{0, 1, 2, 16, 100, 511};

  initial begin
    logic [31:0] a;
    int          kind;
    Reset = 1'b1; ALUResultM = 0; WriteDataM = 0; WriteRegM = 0;
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; MemtoRegM = 0;

    // A store held through reset is dropped; the reset values are then checked.
    step(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0);
    step(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0);
    step(0, 32'h10, 32'h0, 5'd4, 1, 1, 0, 1);
    // A store followed by a load of the same word.
    step(0, 32'h40, 32'h12345678, 5'd0, 0, 0, 1, 0);
    step(0, 32'h40, 32'h0, 5'd8, 1, 1, 0, 1);
    // ALU forwarding and retirement.
    step(0, 32'hAA, 32'h0, 5'd3, 1, 0, 0, 0);
    step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    // A write to $0 is squashed.
    step(0, 32'h55, 32'h0, 5'd0, 1, 0, 0, 0);
    step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    // The address wraps: 0x800 aliases 0x000.
    step(0, 32'h800, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0);
    step(0, 32'h000, 32'h0, 5'd9, 1, 1, 0, 1);
    // A misaligned store, then a load of the aligned word.
    step(0, 32'h41, 32'h1, 5'd0, 0, 0, 1, 0);
    step(0, 32'h40, 32'h0, 5'd10, 1, 1, 0, 1);
    step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    // Load and store in one instruction return the pre-write word.
    step(0, 32'h44, 32'h77777777, 5'd11, 1, 1, 1, 1);
    step(0, 32'h44, 32'h0, 5'd11, 1, 1, 0, 1);

    // Random traffic over a small pool of aliased and misaligned addresses.
    for (int i = 0; i < 500; i++) begin
      a = pool[$urandom_range(0, 5)] * 4 + $urandom_range(0, 3) * WORDS * 4;
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      kind = $urandom_range(0, 3);
      case (kind)
        0: step($urandom_range(0, 49) == 0, $urandom, $urandom, 5'($urandom), 0, 0, 0, 0);
        1: step(0, $urandom, $urandom, 5'($urandom_range(0, 7)), 1, 0, 0, 0);
        2: step(0, a, $urandom, 5'($urandom_range(0, 7)), 1, 1, 0, 1);
        default: step($urandom_range(0, 49) == 0, a, $urandom, 5'($urandom), 0, 0, 1, 0);
      endcase
    end
    step(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);

    repeat (3) @(negedge Clock);
    chk("scoreboard_drain", rd_q.size() + wb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
